// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: drives TMS/TDI/TRST to load one instruction and shift one test vector,
// tracking the target TAP state and capturing TDO during the DR shift.
module jtag_tap_sequencer #(
    parameter int RESET_TMS_CYCLES = 5,
    parameter int MAX_VECTOR_WIDTH = 32,
    parameter int MAX_INSTR_WIDTH  = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [MAX_INSTR_WIDTH-1:0]  req_instr,
    input  logic [2:0]                  req_instr_width,
    input  logic [MAX_VECTOR_WIDTH-1:0] req_vector,
    input  logic [5:0]                  req_vector_width,
    input  logic                        req_trst_en,
    output logic                        jtag_tms,
    output logic                        jtag_tdi,
    output logic                        jtag_trst_n,
    input  logic                        jtag_tdo,
    output logic                        rsp_valid,
    output logic [MAX_VECTOR_WIDTH-1:0] rsp_data,
    output logic                        rsp_err,
    output logic [3:0]                  tap_state
);
    localparam logic [3:0] jtagResetState     = 4'd0;
    localparam logic [3:0] jtagIdleState      = 4'd1;
    localparam logic [3:0] jtagSelectDrState  = 4'd2;
    localparam logic [3:0] jtagSelectIrState  = 4'd3;
    localparam logic [3:0] jtagCaptureIrState = 4'd4;
    localparam logic [3:0] jtagShiftIrState   = 4'd5;
    localparam logic [3:0] jtagExit1IrState   = 4'd6;
    localparam logic [3:0] jtagPauseIrState   = 4'd7;
    localparam logic [3:0] jtagExit2IrState   = 4'd8;
    localparam logic [3:0] jtagUpdateIrState  = 4'd9;
    localparam logic [3:0] jtagCaptureDrState = 4'd10;
    localparam logic [3:0] jtagShiftDrState   = 4'd11;
    localparam logic [3:0] jtagExit1DrState   = 4'd12;
    localparam logic [3:0] jtagPauseDrState   = 4'd13;
    localparam logic [3:0] jtagExit2DrState   = 4'd14;
    localparam logic [3:0] jtagUpdateDrState  = 4'd15;

    localparam logic [2:0] phInit     = 3'd0;
    localparam logic [2:0] phIdle     = 3'd1;
    localparam logic [2:0] phErr      = 3'd2;
    localparam logic [2:0] phTrst     = 3'd3;
    localparam logic [2:0] phTrstIdle = 3'd4;
    localparam logic [2:0] phRun      = 3'd5;
    localparam logic [2:0] phResp     = 3'd6;

    localparam int CW = $clog2(MAX_VECTOR_WIDTH);
    localparam logic [5:0] rstLen = 6'(RESET_TMS_CYCLES);

    logic [2:0]                  phase;
    logic [5:0]                  cnt;
    logic [5:0]                  nLast;
    logic [5:0]                  mLast;
    logic [CW-1:0]               capIdx;
    logic                        irDone;
    logic [MAX_INSTR_WIDTH-1:0]  instrSh;
    logic [MAX_VECTOR_WIDTH-1:0] vecSh;
    logic [3:0]                  nextTap;
    logic                        tmsNext;
    logic                        accept;
    logic                        legal;

    assign accept = req_valid && req_ready;
    assign legal  = req_instr_width >= 3'd3 && req_instr_width <= 3'd5 &&
                    (req_vector_width inside {6'd8, 6'd16, 6'd24, 6'd32});

    // IEEE 1149.1 transition taken by the target on the coming edge
    always_comb begin
        case (tap_state)
            jtagResetState:     nextTap = jtag_tms ? jtagResetState    : jtagIdleState;
            jtagIdleState:      nextTap = jtag_tms ? jtagSelectDrState : jtagIdleState;
            jtagSelectDrState:  nextTap = jtag_tms ? jtagSelectIrState : jtagCaptureDrState;
            jtagSelectIrState:  nextTap = jtag_tms ? jtagResetState    : jtagCaptureIrState;
            jtagCaptureIrState: nextTap = jtag_tms ? jtagExit1IrState  : jtagShiftIrState;
            jtagShiftIrState:   nextTap = jtag_tms ? jtagExit1IrState  : jtagShiftIrState;
            jtagExit1IrState:   nextTap = jtag_tms ? jtagUpdateIrState : jtagPauseIrState;
            jtagPauseIrState:   nextTap = jtag_tms ? jtagExit2IrState  : jtagPauseIrState;
            jtagExit2IrState:   nextTap = jtag_tms ? jtagUpdateIrState : jtagShiftIrState;
            jtagUpdateIrState:  nextTap = jtag_tms ? jtagSelectDrState : jtagIdleState;
            jtagCaptureDrState: nextTap = jtag_tms ? jtagExit1DrState  : jtagShiftDrState;
            jtagShiftDrState:   nextTap = jtag_tms ? jtagExit1DrState  : jtagShiftDrState;
            jtagExit1DrState:   nextTap = jtag_tms ? jtagUpdateDrState : jtagPauseDrState;
            jtagPauseDrState:   nextTap = jtag_tms ? jtagExit2DrState  : jtagPauseDrState;
            jtagExit2DrState:   nextTap = jtag_tms ? jtagUpdateDrState : jtagShiftDrState;
            default:            nextTap = jtag_tms ? jtagSelectDrState : jtagIdleState;
        endcase
    end

    // TMS to present while the target sits in nextTap; cnt counts shift cycles already issued
    always_comb begin
        case (nextTap)
            jtagSelectDrState: tmsNext = !irDone;
            jtagShiftIrState:  tmsNext = cnt == nLast;
            jtagShiftDrState:  tmsNext = cnt == mLast;
            jtagExit1IrState, jtagUpdateIrState, jtagExit1DrState: tmsNext = 1'b1;
            default:           tmsNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase       <= phInit;
            cnt         <= '0;
            nLast       <= '0;
            mLast       <= '0;
            capIdx      <= '0;
            irDone      <= 1'b0;
            instrSh     <= '0;
            vecSh       <= '0;
            jtag_tms    <= 1'b1;
            jtag_tdi    <= 1'b0;
            jtag_trst_n <= 1'b1;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            tap_state   <= jtagResetState;
        end else begin
            tap_state <= phase == phTrst ? jtagResetState : nextTap;
            case (phase)
                phInit: begin
                    jtag_tms <= cnt + 6'd1 < rstLen;
                    cnt      <= cnt == rstLen ? '0 : cnt + 6'd1;
                    if (cnt == rstLen) begin
                        phase     <= phIdle;
                        req_ready <= 1'b1;
                    end
                end
                phIdle: begin
                    jtag_tms <= 1'b0;
                    if (accept) begin
                        req_ready   <= 1'b0;
                        rsp_data    <= '0;
                        capIdx      <= '0;
                        irDone      <= 1'b0;
                        cnt         <= '0;
                        instrSh     <= req_instr;
                        vecSh       <= req_vector;
                        nLast       <= {3'b000, req_instr_width} - 6'd1;
                        mLast       <= req_vector_width - 6'd1;
                        jtag_tms    <= legal && !req_trst_en;
                        jtag_trst_n <= !(legal && req_trst_en);
                        phase       <= !legal ? phErr : req_trst_en ? phTrst : phRun;
                    end
                end
                phErr: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    phase     <= phResp;
                end
                phTrst: begin
                    jtag_trst_n <= 1'b1;
                    jtag_tms    <= 1'b0;
                    phase       <= phTrstIdle;
                end
                phTrstIdle: begin
                    jtag_tms <= 1'b1;
                    phase    <= phRun;
                end
                phRun: begin
                    jtag_tms <= tmsNext;
                    cnt      <= (nextTap == jtagShiftIrState || nextTap == jtagShiftDrState) ? cnt + 6'd1 : '0;
                    jtag_tdi <= nextTap == jtagShiftIrState ? instrSh[0] : nextTap == jtagShiftDrState && vecSh[0];
                    if (nextTap == jtagShiftIrState)
                        instrSh <= instrSh >> 1;
                    if (nextTap == jtagShiftDrState)
                        vecSh <= vecSh >> 1;
                    if (nextTap == jtagUpdateIrState)
                        irDone <= 1'b1;
                    if (tap_state == jtagShiftDrState) begin
                        rsp_data[capIdx] <= jtag_tdo;
                        capIdx           <= capIdx + CW'(1);
                    end
                    if (nextTap == jtagIdleState) begin
                        rsp_valid <= 1'b1;
                        phase     <= phResp;
                    end
                end
                phResp: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    phase     <= phIdle;
                end
                default: phase <= phInit;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb_jtag_tap_sequencer: directed checks of pin sequences, capture, TRST, error path and mid-scan reset.
module tb_jtag_tap_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_instr = '0;
    logic [2:0]  req_instr_width = '0;
    logic [31:0] req_vector = '0;
    logic [5:0]  req_vector_width = '0;
    logic        req_trst_en = 1'b0;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_trst_n;
    logic        jtag_tdo;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  tap_state;
    logic        tdoDly = 1'b0;
    logic        tdoReg;
    int          nTests = 0;
    int          nFail = 0;

    jtag_tap_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_instr_width(req_instr_width),
        .req_vector(req_vector), .req_vector_width(req_vector_width),
        .req_trst_en(req_trst_en),
        .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_trst_n(jtag_trst_n), .jtag_tdo(jtag_tdo),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) tdoReg <= !reset ? 1'b0 : jtag_tdi;

    assign jtag_tdo = tdoDly ? tdoReg : jtag_tdi;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tmsModel(input int n, input int m, input bit trst);
        logic [63:0] s;
        int b;
        s = '0;
        b = trst ? 2 : 0;
        s[6'(b)] = 1'b1;
        s[6'(b + 1)] = 1'b1;
        s[6'(b + 3 + n)] = 1'b1;
        s[6'(b + 4 + n)] = 1'b1;
        s[6'(b + 5 + n)] = 1'b1;
        s[6'(b + 7 + n + m)] = 1'b1;
        s[6'(b + 8 + n + m)] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] tdiModel(input int n, input int m, input bit trst,
                                             input logic [4:0] instr, input logic [31:0] vec);
        logic [63:0] s;
        int b;
        s = '0;
        b = trst ? 2 : 0;
        for (int i = 0; i < n; i++) s[6'(b + 4 + i)] = instr[3'(i)];
        for (int j = 0; j < m; j++) s[6'(b + 8 + n + j)] = vec[5'(j)];
        return s;
    endfunction

    task automatic checkResetVals(input string tag);
        check({tag, "_tms"}, 64'(jtag_tms), 64'd1);
        check({tag, "_tdi"}, 64'(jtag_tdi), 64'd0);
        check({tag, "_trst"}, 64'(jtag_trst_n), 64'd1);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rspv"}, 64'(rsp_valid), 64'd0);
        check({tag, "_data"}, 64'(rsp_data), 64'd0);
        check({tag, "_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_tap"}, 64'(tap_state), 64'd0);
    endtask

    task automatic resetSeq();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            check("init_tms", 64'(jtag_tms), 64'(k < 5));
            check("init_ready", 64'(req_ready), 64'(k == 6));
            check("init_tap", 64'(tap_state), k == 6 ? 64'd1 : 64'd0);
            check("init_rsp", 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic startReq(input logic [4:0] instr, input logic [2:0] iw, input logic [31:0] vec,
                            input logic [5:0] vw, input logic trst);
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
        check("ready_wait", 64'(req_ready), 64'd1);
        req_instr = instr;
        req_instr_width = iw;
        req_vector = vec;
        req_vector_width = vw;
        req_trst_en = trst;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic runReq(input logic [4:0] instr, input logic [2:0] iw, input logic [31:0] vec,
                          input logic [5:0] vw, input logic trst, input logic [31:0] expData,
                          input logic expErr);
        int n, m, b, len, rspK;
        logic [63:0] tmsS, tdiS, trstS, tmsE, tdiE, trstE;
        logic [3:0] tapS [64];
        n = int'(iw);
        m = int'(vw);
        b = trst ? 2 : 0;
        len = expErr ? 1 : b + n + m + 10;
        rspK = -1;
        tmsS = '0;
        tdiS = '0;
        trstS = '0;
        tmsE = expErr ? 64'd0 : tmsModel(n, m, trst);
        tdiE = expErr ? 64'd0 : tdiModel(n, m, trst, instr, vec);
        trstE = ~64'd0 >> (63 - len);
        if (trst && !expErr) trstE[0] = 1'b0;
        startReq(instr, iw, vec, vw, trst);
        for (int k = 0; k < 64 && rspK < 0; k++) begin
            @(negedge clk);
            tmsS[6'(k)] = jtag_tms;
            tdiS[6'(k)] = jtag_tdi;
            trstS[6'(k)] = jtag_trst_n;
            tapS[6'(k)] = tap_state;
            if (k == 0) begin
                check("ack_ready", 64'(req_ready), 64'd0);
                check("ack_clear", 64'(rsp_data), 64'd0);
            end
            if (rsp_valid) rspK = k;
        end
        check("rsp_latency", 64'(rspK), 64'(len));
        check("tms_seq", tmsS, tmsE);
        check("tdi_seq", tdiS, tdiE);
        check("trst_seq", trstS, trstE);
        check("rsp_err", 64'(rsp_err), 64'(expErr));
        check("rsp_data", 64'(rsp_data), 64'(expData));
        check("rsp_tap", 64'(tap_state), 64'd1);
        if (!expErr) begin
            check("tap_shift_ir", 64'(tapS[6'(b + 4)]), 64'd5);
            check("tap_shift_dr", 64'(tapS[6'(b + 8 + n)]), 64'd11);
            check("tap_update_dr", 64'(tapS[6'(b + 9 + n + m)]), 64'd15);
            if (trst) check("tap_trst", 64'(tapS[1]), 64'd0);
        end
        @(negedge clk);
        check("rsp_pulse", 64'(rsp_valid), 64'd0);
        check("ready_back", 64'(req_ready), 64'd1);
        check("rsp_hold", 64'(rsp_data), 64'(expData));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkResetVals("por");
        resetSeq();
        runReq(5'b00110, 3'd5, 32'h000000A5, 6'd8, 1'b0, 32'h000000A5, 1'b0);
        tdoDly = 1'b1;
        runReq(5'b00000, 3'd5, 32'h000000A5, 6'd8, 1'b0, 32'h0000004A, 1'b0);
        runReq(5'b00110, 3'd5, 32'h000000A5, 6'd6, 1'b0, 32'h00000000, 1'b1);
        runReq(5'b00011, 3'd6, 32'h000000A5, 6'd8, 1'b1, 32'h00000000, 1'b1);
        tdoDly = 1'b0;
        runReq(5'b00101, 3'd3, 32'h00001234, 6'd16, 1'b1, 32'h00001234, 1'b0);
        runReq(5'b01001, 3'd4, 32'hDEADBEEF, 6'd32, 1'b0, 32'hDEADBEEF, 1'b0);
        tdoDly = 1'b1;
        runReq(5'b10110, 3'd5, 32'h00C3A5F0, 6'd24, 1'b0, 32'h00874BE0, 1'b0);
        tdoDly = 1'b0;
        startReq(5'b00110, 3'd5, 32'h000000A5, 6'd8, 1'b0);
        repeat (17) @(negedge clk);
        check("mid_tap", 64'(tap_state), 64'd11);
        reset = 1'b0;
        #1;
        checkResetVals("mid");
        repeat (3) begin
            @(negedge clk);
            check("mid_quiet", 64'(rsp_valid), 64'd0);
        end
        resetSeq();
        runReq(5'b00110, 3'd5, 32'hFFFF005A, 6'd8, 1'b0, 32'h0000005A, 1'b0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
